// File: rtl/cpu_defs.sv
// Shared CPU definitions: placement of the VRAM window and its address decode,
// used by both the CPU store path and the VRAM write queue.
package cpu_defs;

    localparam int          VRAM_AW        = 14;
    localparam logic [31:0] VRAM_BASE_ADDR = 32'h0001_0000;

    // The window spans 4*2^aw bytes, so only the bits above the word index are compared.
    function automatic logic in_vram_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          aw);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (aw + 2);
        return ((addr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/vram_write_queue_if.sv
// CPU store side and VRAM drain side of the write queue, bundled with
// master (CPU/VRAM environment) and slave (queue) views.
interface vram_write_queue_if
    import cpu_defs::*;
#(
    parameter int AW = VRAM_AW,
    parameter int CW = 4
);
    logic [31:0]   vramaddr;
    logic          vramwe;
    logic [31:0]   vramdata;
    logic          stall_vram;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_data;
    logic [CW-1:0] count;
    logic          oor;

    modport slave (
        input  vramaddr, vramwe, vramdata, out_ready,
        output stall_vram, out_valid, out_addr, out_data, count, oor
    );

    modport master (
        output vramaddr, vramwe, vramdata, out_ready,
        input  stall_vram, out_valid, out_addr, out_data, count, oor
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Entry storage for the write queue: {addr, data} words with a push port,
// an in-place overwrite of the newest entry, and a head read port.
module sync_fifo_mem
    import cpu_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = VRAM_AW
)(
    input  logic           clk,
    input  logic           clrn,
    input  logic           push,
    input  logic           overwrite,
    input  logic           pop,
    input  logic [AW+31:0] wdata,
    output logic [AW+31:0] rdata,
    output logic [AW-1:0]  tail_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int W  = AW + 32;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] tail_ptr_s;
    logic [W-1:0]  mem_r [DEPTH];

    // Newest entry sits just behind the write pointer; pointers wrap naturally at DEPTH.
    assign tail_ptr_s = wr_ptr_r - PW'(1);
    assign rdata      = mem_r[rd_ptr_r];
    assign tail_addr  = mem_r[tail_ptr_s][W-1:32];

    // Pointer and storage update; entries are cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else if (overwrite) begin
                mem_r[tail_ptr_s] <= wdata;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// Posted-write queue between the CPU store path and the VRAM port: decodes the
// VRAM window, coalesces repeated stores to the newest entry and back-pressures when full.
module vram_write_queue
    import cpu_defs::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          AW        = VRAM_AW,
    parameter logic [31:0] VRAM_BASE = VRAM_BASE_ADDR
)(
    input  logic                clk,
    input  logic                clrn,
    vram_write_queue_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]  count_r;
    logic [CW-1:0]  count_next_s;
    logic           valid_r;
    logic           stall_r;
    logic           oor_r;
    logic           in_win_s;
    logic           accept_s;
    logic           push_s;
    logic           coalesce_s;
    logic           pop_s;
    logic [AW-1:0]  waddr_s;
    logic [AW-1:0]  tail_addr_s;
    logic [AW+31:0] head_s;

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .clrn      (clrn),
        .push      (push_s),
        .overwrite (coalesce_s),
        .pop       (pop_s),
        .wdata     ({waddr_s, bus.vramdata}),
        .rdata     (head_s),
        .tail_addr (tail_addr_s)
    );

    // Accept/coalesce decision; the head is never touched, so coalescing needs at least two entries.
    always_comb begin
        in_win_s     = in_vram_window(bus.vramaddr, VRAM_BASE, AW);
        waddr_s      = bus.vramaddr[AW+1:2];
        accept_s     = bus.vramwe & ~stall_r;
        pop_s        = valid_r & bus.out_ready;
        push_s       = 1'b0;
        coalesce_s   = 1'b0;
        count_next_s = count_r;
        if (accept_s && in_win_s) begin
            if ((count_r >= CW'(2)) && (waddr_s == tail_addr_s)) begin
                coalesce_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s     = 1'b0;
            coalesce_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy and flags; valid/stall are precomputed so they depend on registers only.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_r <= {CW{1'b0}};
            valid_r <= 1'b0;
            stall_r <= 1'b0;
            oor_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            valid_r <= (count_next_s != {CW{1'b0}});
            stall_r <= (count_next_s == CW'(DEPTH));
            oor_r   <= oor_r | (accept_s & ~in_win_s);
        end
    end

    assign bus.count      = count_r;
    assign bus.out_valid  = valid_r;
    assign bus.stall_vram = stall_r;
    assign bus.oor        = oor_r;
    assign bus.out_addr   = head_s[AW+31:32];
    assign bus.out_data   = head_s[31:0];

endmodule
